// File: rtl/lvt_mem_port_arbiter_pkg.sv
// Shared parameters for the LVT memory port arbiter slice.
// WORD / MEM_ADDR / MAX_NUM_REQ are the bank-wide parameter macros; the
// guards let an enclosing build override them before this file is read.
`ifndef WORD
`define WORD 16
`endif
`ifndef MEM_ADDR
`define MEM_ADDR 8
`endif
`ifndef MAX_NUM_REQ
`define MAX_NUM_REQ 8
`endif

package lvt_mem_port_arbiter_pkg;

  localparam int WORD_W  = `WORD;
  localparam int ADDR_W  = `MEM_ADDR;
  localparam int MAX_REQ = `MAX_NUM_REQ;
  localparam int MIN_REQ = 2;

  // Width of a round-robin pointer over n requesters (at least 1 bit).
  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lvt_mem_port_arbiter_mem.sv
// 1-write / 1-read bank with a registered read. A read and a write to the
// same address on one edge return the old contents. Storage is not reset.
module MEM_1w1r
  import lvt_mem_port_arbiter_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = WORD_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port and registered read port share the clock edge.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lvt_mem_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from ptr upward, pointer
// advances past the winner, holds when nothing is granted.
module rr_arbiter
  import lvt_mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_any
);

  localparam int PW = ptr_w(NUM_REQ);

  logic [PW-1:0] ptr_q, ptr_d;

  // Priority search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    int win;
    gnt     = '0;
    gnt_any = 1'b0;
    win     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end
    if (gnt_any)
      ptr_d = (win == NUM_REQ - 1) ? '0 : PW'(win + 1);
    else
      ptr_d = ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lvt_mem_port_arbiter.sv
// Shares one MEM_1w1r bank between NUM_REQ requesters. Write and read ports
// have independent round-robin arbiters; read data returns one cycle after
// grant with a one-hot tag. Optional same-cycle write-to-read bypass.
module lvt_mem_port_arbiter
  import lvt_mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,   // 2..MAX_REQ
  parameter int BYPASS  = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WORD_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_gnt,
  output logic                      rd_valid,
  output logic [NUM_REQ-1:0]        rd_tag,
  output logic [WORD_W-1:0]         rd_data
);

  logic [NUM_REQ-1:0] wr_req, rd_req, wr_gnt, rd_gnt;
  logic               wr_any, rd_any, mem_we;
  logic [ADDR_W-1:0]  waddr, raddr;
  logic [WORD_W-1:0]  wdata, mem_rdata;

  logic               rd_valid_q, rd_valid_d;
  logic [NUM_REQ-1:0] rd_tag_q, rd_tag_d;
  logic               byp_q, byp_d;
  logic [WORD_W-1:0]  byp_data_q, byp_data_d;

  // req_we steers each requester to exactly one arbiter.
  assign wr_req = req_valid & req_we;
  assign rd_req = req_valid & ~req_we;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clk(clock), .rst(reset), .req(wr_req), .gnt(wr_gnt), .gnt_any(wr_any)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clk(clock), .rst(reset), .req(rd_req), .gnt(rd_gnt), .gnt_any(rd_any)
  );

  // Select winner lanes by one-hot grant; losing lanes (possibly X) never
  // reach the bank.
  always_comb begin
    waddr = '0;
    wdata = '0;
    raddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        waddr = req_addr[i*ADDR_W +: ADDR_W];
        wdata = req_wdata[i*WORD_W +: WORD_W];
      end
      if (rd_gnt[i]) raddr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign mem_we  = wr_any & ~reset;
  assign req_gnt = reset ? '0 : (wr_gnt | rd_gnt);

  MEM_1w1r #(.AW(ADDR_W), .DW(WORD_W)) u_mem (
    .clk(clock), .we(mem_we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(mem_rdata)
  );

  // Next-state for read return: tag, valid and the registered bypass choice.
  always_comb begin
    rd_valid_d = rd_any;
    rd_tag_d   = rd_gnt;
    byp_d      = (BYPASS != 0) && mem_we && rd_any && (waddr == raddr);
    byp_data_d = wdata;
  end

  // Read-return registers; reset drops any in-flight read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_tag   = rd_tag_q;
  assign rd_data  = byp_q ? byp_data_q : mem_rdata;

endmodule

// File: tb/tb_lvt_mem_port_arbiter.sv
// Directed bench for lvt_mem_port_arbiter: BYPASS=1 main instance plus a
// BYPASS=0 instance sharing the same stimulus for the same-address case.
module tb_lvt_mem_port_arbiter;
  import lvt_mem_port_arbiter_pkg::*;

  localparam int N = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic [N-1:0]        req_valid, req_we;
  logic [N*ADDR_W-1:0] req_addr;
  logic [N*WORD_W-1:0] req_wdata;

  logic [N-1:0]        req_gnt, req_gnt_nb;
  logic                rd_valid, rd_valid_nb;
  logic [N-1:0]        rd_tag, rd_tag_nb;
  logic [WORD_W-1:0]   rd_data, rd_data_nb;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  lvt_mem_port_arbiter #(.NUM_REQ(N), .BYPASS(1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_gnt(req_gnt),
    .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_data(rd_data)
  );

  lvt_mem_port_arbiter #(.NUM_REQ(N), .BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_gnt(req_gnt_nb),
    .rd_valid(rd_valid_nb), .rd_tag(rd_tag_nb), .rd_data(rd_data_nb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    req_valid[i] = v;
    req_we[i]    = we;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*WORD_W +: WORD_W] = d;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  initial begin
    logic [N-1:0] exp_g [5];
    logic [N-1:0] prev_g;

    // ---- reset: grants suppressed even with requests pending
    reset = 1'b1;
    idle();
    req_valid = '1;
    #2;
    chk("gnt_in_reset", 32'(req_gnt), 32'h0);
    chk("rdv_in_reset", 32'(rd_valid), 32'h0);
    chk("tag_in_reset", 32'(rd_tag), 32'h0);
    tick(); tick();
    idle();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("idle_gnt", 32'(req_gnt), 32'h0);
      chk("idle_rdv", 32'(rd_valid), 32'h0);
      tick();
    end

    // ---- all four write continuously; grant rotates from requester 0
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, ADDR_W'(8'h10 + i), WORD_W'(8'hA0 + i));
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("wr_rotate", 32'(req_gnt), 32'(exp_g[c]));
      tick();
    end
    idle();

    // ---- read back 0x10..0x13 through requester 0
    for (int a = 0; a < N; a++) begin
      set_req(0, 1'b1, 1'b0, ADDR_W'(8'h10 + a), '0);
      #1;
      chk("rb_gnt", 32'(req_gnt), 32'h1);
      tick();
      chk("rb_valid", 32'(rd_valid), 32'h1);
      chk("rb_tag", 32'(rd_tag), 32'h1);
      chk("rb_data", 32'(rd_data), 32'(8'hA0 + a));
    end
    idle();

    // ---- seed 0x5 = 0x1111
    set_req(0, 1'b1, 1'b1, 8'h05, 16'h1111);
    tick();
    idle();
    tick();
    chk("rdv_fall", 32'(rd_valid), 32'h0);

    // ---- same-cycle write (req1) and read (req2) of 0x5; idle lanes are X
    set_req(1, 1'b1, 1'b1, 8'h05, 16'hDEAD);
    set_req(2, 1'b1, 1'b0, 8'h05, 'x);
    req_addr[0*ADDR_W +: ADDR_W]  = 'x;
    req_wdata[0*WORD_W +: WORD_W] = 'x;
    req_addr[3*ADDR_W +: ADDR_W]  = 'x;
    req_wdata[3*WORD_W +: WORD_W] = 'x;
    #1;
    chk("raw_gnt", 32'(req_gnt), 32'b0110);
    tick();
    chk("raw_valid", 32'(rd_valid), 32'h1);
    chk("raw_tag", 32'(rd_tag), 32'b0100);
    chk("raw_byp1", 32'(rd_data), 32'hDEAD);
    chk("raw_byp0", 32'(rd_data_nb), 32'h1111);
    idle();

    // ---- write 0x7 at edge N, read at edge N+1
    set_req(3, 1'b1, 1'b1, 8'h07, 16'hBEEF);
    tick();
    chk("no_rd_gnt_valid", 32'(rd_valid), 32'h0);
    idle();
    set_req(0, 1'b1, 1'b0, 8'h07, '0);
    tick();
    chk("waw_tag", 32'(rd_tag), 32'h1);
    chk("waw_data", 32'(rd_data), 32'hBEEF);
    chk("waw_data_nb", 32'(rd_data_nb), 32'hBEEF);
    idle();

    // ---- requesters 0 and 3 read continuously; rd_ptr sits at 1 so 3 wins first
    set_req(0, 1'b1, 1'b0, 8'h10, '0);
    set_req(3, 1'b1, 1'b0, 8'h13, '0);
    exp_g[0] = 4'b1000; exp_g[1] = 4'b0001; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rd_alt_gnt", 32'(req_gnt), 32'(exp_g[c]));
      prev_g = exp_g[c];
      tick();
      chk("rd_alt_tag", 32'(rd_tag), 32'(prev_g));
      chk("rd_alt_data", 32'(rd_data), prev_g[0] ? 32'hA0 : 32'hA3);
    end
    idle();

    // ---- reset right after a read grant; rd_ptr would otherwise favour 3
    set_req(2, 1'b1, 1'b0, 8'h11, '0);
    tick();
    chk("pre_rst_valid", 32'(rd_valid), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_drop_valid", 32'(rd_valid), 32'h0);
    chk("rst_drop_tag", 32'(rd_tag), 32'h0);
    chk("rst_gnt", 32'(req_gnt), 32'h0);
    tick();
    idle();
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h10, '0);
    set_req(3, 1'b1, 1'b0, 8'h13, '0);
    #1;
    chk("post_rst_gnt", 32'(req_gnt), 32'h1);
    tick();
    chk("post_rst_tag", 32'(rd_tag), 32'h1);
    chk("post_rst_data", 32'(rd_data), 32'hA0);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
